// File: rtl/cic_comp_fir_pkg.sv
// Shared state type, coefficient tables and arithmetic helpers for the
// CIC droop-compensation FIR.
package cic_comp_package;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      RND  = 2'd2
   } fir_state_t;

   localparam int TABLE_TAPS       = 16;
   localparam int TABLE_COEF_WIDTH = 18;
   localparam int SAT_W            = 64;

   // Set 0: symmetric Q1.17 droop compensation with unity DC gain. Set 1: ramp (k+1)*2^12.
   localparam logic signed [TABLE_COEF_WIDTH-1:0] COEF_TABLE [0:1][0:TABLE_TAPS-1] = '{
      '{-18'sd170,   18'sd420,   -18'sd890,  18'sd1640, -18'sd2880, 18'sd5050,
        -18'sd9450,  18'sd71816,  18'sd71816, -18'sd9450, 18'sd5050, -18'sd2880,
         18'sd1640, -18'sd890,    18'sd420,  -18'sd170},
      '{ 18'sd4096,  18'sd8192,  18'sd12288, 18'sd16384, 18'sd20480, 18'sd24576,
         18'sd28672, 18'sd32768, 18'sd36864, 18'sd40960, 18'sd45056, 18'sd49152,
         18'sd53248, 18'sd57344, 18'sd61440, 18'sd65536}
   };

   function automatic int acc_width(input int din_width, input int coef_width, input int num_taps);
      return din_width + coef_width + $clog2(num_taps);
   endfunction

   // Round half up, drop frac_bits, then clamp to a signed out_width range.
   function automatic logic signed [SAT_W-1:0] sat_round(input logic signed [SAT_W-1:0] acc,
                                                         input int frac_bits,
                                                         input int out_width);
      logic signed [SAT_W-1:0] rnd_s;
      logic signed [SAT_W-1:0] max_s;
      logic signed [SAT_W-1:0] min_s;
      rnd_s = (acc + (64'sd1 <<< (frac_bits - 1))) >>> frac_bits;
      max_s = (64'sd1 <<< (out_width - 1)) - 64'sd1;
      min_s = -(64'sd1 <<< (out_width - 1));
      if (rnd_s > max_s) begin
         return max_s;
      end else if (rnd_s < min_s) begin
         return min_s;
      end else begin
         return rnd_s;
      end
   endfunction

endpackage

// File: rtl/cic_comp_fir_axis_out_reg.sv
// One-entry AXI4-Stream output register; a result arriving while the slot is
// full and not draining is dropped and flagged.
module axis_out_reg #(
   parameter int WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    load_valid,
   input  logic signed [WIDTH-1:0] load_data,
   input  logic                    tready,
   output logic signed [WIDTH-1:0] tdata,
   output logic                    tvalid,
   output logic                    drop
);

   logic accept_s;

   // Slot can take a new result when empty or being drained this cycle.
   always_comb begin
      accept_s = !tvalid || tready;
      drop     = load_valid && !accept_s;
   end

   // Output slot: load, drain on handshake, otherwise hold.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tdata  <= '0;
         tvalid <= 1'b0;
      end else if (load_valid && accept_s) begin
         tdata  <= load_data;
         tvalid <= 1'b1;
      end else if (tready) begin
         tvalid <= 1'b0;
      end else begin
         tvalid <= tvalid;
      end
   end

endmodule

// File: rtl/cic_comp_fir.sv
// Serial-MAC CIC compensation FIR with output decimation; one multiplier
// shared across all taps, result presented on an AXI4-Stream master.
module cic_comp_fir
   import cic_comp_package::*;
#(
   parameter int DATA_IN_WIDTH  = 16,
   parameter int DATA_OUT_WIDTH = 16,
   parameter int COEF_WIDTH     = 18,
   parameter int COEF_FRAC_BITS = 17,
   parameter int NUM_TAPS       = 16,
   parameter int FIR_DECIMATION = 2,
   parameter int COEF_SET       = 0
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic signed [DATA_IN_WIDTH-1:0]  data_in,
   input  logic                             in_dv,
   output logic signed [DATA_OUT_WIDTH-1:0] m_axis_tdata,
   output logic                             m_axis_tvalid,
   input  logic                             m_axis_tready,
   output logic                             overrun,
   input  logic                             clear_overrun
);

   localparam int ACC_W  = acc_width(DATA_IN_WIDTH, COEF_WIDTH, NUM_TAPS);
   localparam int PROD_W = DATA_IN_WIDTH + COEF_WIDTH;
   localparam int K_W    = $clog2(NUM_TAPS);
   localparam int PH_W   = (FIR_DECIMATION > 1) ? $clog2(FIR_DECIMATION) : 1;
   localparam logic [K_W-1:0]  LAST_TAP   = K_W'(NUM_TAPS - 1);
   localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(FIR_DECIMATION - 1);

   logic signed [COEF_WIDTH-1:0]     coef_s [NUM_TAPS];
   logic signed [DATA_IN_WIDTH-1:0]  x_r    [NUM_TAPS];
   logic        [PH_W-1:0]           phase_r;
   logic        [K_W-1:0]            k_r;
   logic signed [ACC_W-1:0]          acc_r;
   fir_state_t                       state_r;
   logic signed [DATA_OUT_WIDTH-1:0] res_r;
   logic                             res_vld_r;
   logic                             due_s;
   logic                             abort_s;
   logic                             drop_s;
   logic signed [PROD_W-1:0]         prod_s;
   logic signed [DATA_OUT_WIDTH-1:0] res_s;

   // Taps beyond the stored table are zero.
   for (genvar t = 0; t < NUM_TAPS; t++) begin : g_coef
      if (t < TABLE_TAPS) begin : g_tab
         assign coef_s[t] = COEF_WIDTH'(COEF_TABLE[COEF_SET][t]);
      end else begin : g_zero
         assign coef_s[t] = '0;
      end
   end

   // Tap product, input-collision detection and the rounded/saturated result.
   always_comb begin
      due_s   = in_dv && (phase_r == LAST_PHASE);
      abort_s = in_dv && (state_r != IDLE);
      prod_s  = PROD_W'(x_r[k_r]) * PROD_W'(coef_s[k_r]);
      res_s   = DATA_OUT_WIDTH'(sat_round(SAT_W'(acc_r), COEF_FRAC_BITS, DATA_OUT_WIDTH));
   end

   // Delay line, decimation phase and the MAC sequencer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_TAPS; i++) begin
            x_r[i] <= '0;
         end
         phase_r   <= '0;
         k_r       <= '0;
         acc_r     <= '0;
         state_r   <= IDLE;
         res_r     <= '0;
         res_vld_r <= 1'b0;
      end else begin
         res_vld_r <= 1'b0;
         if (in_dv) begin
            x_r[0] <= data_in;
            for (int i = 1; i < NUM_TAPS; i++) begin
               x_r[i] <= x_r[i-1];
            end
            phase_r <= (phase_r == LAST_PHASE) ? '0 : phase_r + 1'b1;
         end
         // A due sample starts a fresh MAC even if it aborts one in flight.
         if (due_s) begin
            state_r <= MAC;
            k_r     <= '0;
            acc_r   <= '0;
         end else if (abort_s) begin
            state_r <= IDLE;
         end else begin
            case (state_r)
               IDLE: state_r <= IDLE;
               MAC: begin
                  acc_r <= acc_r + ACC_W'(prod_s);
                  if (k_r == LAST_TAP) begin
                     state_r <= RND;
                  end else begin
                     k_r <= k_r + 1'b1;
                  end
               end
               RND: begin
                  res_r     <= res_s;
                  res_vld_r <= 1'b1;
                  state_r   <= IDLE;
               end
               default: state_r <= IDLE;
            endcase
         end
      end
   end

   // Sticky overrun; a new event wins over a simultaneous clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overrun <= 1'b0;
      end else if (abort_s || drop_s) begin
         overrun <= 1'b1;
      end else if (clear_overrun) begin
         overrun <= 1'b0;
      end else begin
         overrun <= overrun;
      end
   end

   axis_out_reg #(
      .WIDTH(DATA_OUT_WIDTH)
   ) u_axis_out_reg (
      .clk       (clk),
      .reset_n   (reset_n),
      .load_valid(res_vld_r),
      .load_data (res_r),
      .tready    (m_axis_tready),
      .tdata     (m_axis_tdata),
      .tvalid    (m_axis_tvalid),
      .drop      (drop_s)
   );

endmodule
